// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and memory access,
// favouring data accesses but bounding how long a pending fetch can be passed over.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  localparam int CW = $clog2(MAX_DATA_RUN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic [1:0]    o_dbg_state,
  output logic [CW-1:0] o_dbg_run_cnt
);

  // Handshake: a requester raises req with stable fields and holds it until it sees a
  // one-cycle ack; req still high in the ack cycle is stale and ignored for arbitration.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_run_cnt;
  logic          r_i_ack;
  logic          r_d_ack;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_m_req;
  logic          r_m_wr;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_wdata;

  logic w_i_req_v;
  logic w_d_req_v;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done_i;
  logic w_done_d;

  assign w_i_req_v = i_req & ~r_i_ack;
  assign w_d_req_v = d_req & ~r_d_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d)      w_next_state = S_BUSY_D;
        else if (w_grant_i) w_next_state = S_BUSY_I;
      end
      S_BUSY_I: if (m_ready) w_next_state = S_IDLE;
      S_BUSY_D: if (m_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Data wins a tie unless the run counter says the fetch has waited long enough.
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_done_i  = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_d = w_d_req_v & (~w_i_req_v | (r_run_cnt != RUN_MAX));
        w_grant_i = w_i_req_v & ~w_grant_d;
      end
      S_BUSY_I: w_done_i = m_ready;
      S_BUSY_D: w_done_d = m_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_m_req   <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_i_ack <= w_done_i;
      r_d_ack <= w_done_d;
      if (w_done_i) r_i_rdata <= m_rdata;
      if (w_done_d) r_d_rdata <= m_rdata;
      if (w_done_i | w_done_d) r_m_req <= 1'b0;
      if (w_grant_d) begin
        r_m_req   <= 1'b1;
        r_m_wr    <= d_wr;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
        // Raw i_req: a fetch in its own ack cycle still counts as waiting.
        if (!i_req)                    r_run_cnt <= '0;
        else if (r_run_cnt != RUN_MAX) r_run_cnt <= r_run_cnt + 1'b1;
      end else if (w_grant_i) begin
        r_m_req   <= 1'b1;
        r_m_wr    <= 1'b0;
        r_m_addr  <= i_addr;
        r_run_cnt <= '0;
      end
    end
  end

  assign i_ack         = r_i_ack;
  assign d_ack         = r_d_ack;
  assign i_rdata       = r_i_rdata;
  assign d_rdata       = r_d_rdata;
  assign m_req         = r_m_req;
  assign m_wr          = r_m_wr & r_m_req;
  assign m_addr        = r_m_addr;
  assign m_wdata       = r_m_wdata;
  assign stall_if      = i_req & ~r_i_ack;
  assign stall_mem     = d_req & ~r_d_ack;
  assign o_dbg_state   = r_state;
  assign o_dbg_run_cnt = r_run_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: each task drives one scenario and checks
// the port behaviour cycle by cycle against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        stall_if;
  logic        stall_mem;
  logic [1:0]  o_dbg_state;
  logic [2:0]  o_dbg_run_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .o_dbg_state(o_dbg_state), .o_dbg_run_cnt(o_dbg_run_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_ready = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_req !== 1'b0) $display("FAIL rst_mreq: got %0b want 0", m_req); else n_pass++;
    n_checks++; if (m_wr !== 1'b0) $display("FAIL rst_mwr: got %0b want 0", m_wr); else n_pass++;
    n_checks++; if ({i_ack, d_ack} !== 2'b00) $display("FAIL rst_acks: got %b want 00", {i_ack, d_ack}); else n_pass++;
    n_checks++; if ({m_addr, m_wdata} !== 64'h0) $display("FAIL rst_maddr_wdata: got %h want 0", {m_addr, m_wdata}); else n_pass++;
    n_checks++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {i_rdata, d_rdata}); else n_pass++;
    n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", o_dbg_state); else n_pass++;
    n_checks++; if (o_dbg_run_cnt !== 3'd0) $display("FAIL rst_runcnt: got %0d want 0", o_dbg_run_cnt); else n_pass++;
    rst = 0;
  endtask

  task automatic test_single_write;
    do_reset();
    d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; m_ready = 1;
    #1;
    n_checks++; if (stall_mem !== 1'b1) $display("FAIL wr_stall_c0: got %0b want 1", stall_mem); else n_pass++;
    n_checks++; if (m_req !== 1'b0) $display("FAIL wr_mreq_c0: got %0b want 0", m_req); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b1) $display("FAIL wr_mreq_c1: got %0b want 1", m_req); else n_pass++;
    n_checks++; if (m_wr !== 1'b1) $display("FAIL wr_mwr_c1: got %0b want 1", m_wr); else n_pass++;
    n_checks++; if (m_addr !== 32'h100) $display("FAIL wr_maddr_c1: got %h want 00000100", m_addr); else n_pass++;
    n_checks++; if (m_wdata !== 32'hDEADBEEF) $display("FAIL wr_mwdata_c1: got %h want deadbeef", m_wdata); else n_pass++;
    n_checks++; if (stall_mem !== 1'b1) $display("FAIL wr_stall_c1: got %0b want 1", stall_mem); else n_pass++;
    n_checks++; if (d_ack !== 1'b0) $display("FAIL wr_dack_c1: got %0b want 0", d_ack); else n_pass++;
    tick();
    n_checks++; if (d_ack !== 1'b1) $display("FAIL wr_dack_c2: got %0b want 1", d_ack); else n_pass++;
    n_checks++; if ({m_req, m_wr} !== 2'b00) $display("FAIL wr_mreq_c2: got %b want 00", {m_req, m_wr}); else n_pass++;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL wr_stall_c2: got %0b want 0", stall_mem); else n_pass++;
    tick();
    // d_req was still high in the ack cycle: it must not be granted again
    n_checks++; if (m_req !== 1'b0) $display("FAIL stale_mreq: got %0b want 0", m_req); else n_pass++;
    n_checks++; if (d_ack !== 1'b0) $display("FAIL stale_dack: got %0b want 0", d_ack); else n_pass++;
    n_checks++; if (o_dbg_run_cnt !== 3'd0) $display("FAIL stale_runcnt: got %0d want 0", o_dbg_run_cnt); else n_pass++;
    n_checks++; if (m_addr !== 32'h100) $display("FAIL idle_maddr_hold: got %h want 00000100", m_addr); else n_pass++;
    d_req = 0;
    tick();
    n_checks++; if (m_req !== 1'b0) $display("FAIL stale_mreq2: got %0b want 0", m_req); else n_pass++;
  endtask

  task automatic test_fetch_wait;
    do_reset();
    i_req = 1; i_addr = 32'h40; m_ready = 0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        m_ready = 1; m_rdata = 32'h12345678;
      end
      n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h40)
        $display("FAIL fw_hold_c%0d: got m_req=%0b m_addr=%h want 1 00000040", c, m_req, m_addr); else n_pass++;
      n_checks++; if (i_ack !== 1'b0 || stall_if !== 1'b1)
        $display("FAIL fw_wait_c%0d: got i_ack=%0b stall_if=%0b want 0 1", c, i_ack, stall_if); else n_pass++;
      tick();
    end
    n_checks++; if (i_ack !== 1'b1) $display("FAIL fw_iack_c5: got %0b want 1", i_ack); else n_pass++;
    n_checks++; if (i_rdata !== 32'h12345678) $display("FAIL fw_rdata: got %h want 12345678", i_rdata); else n_pass++;
    n_checks++; if (m_req !== 1'b0) $display("FAIL fw_mreq_c5: got %0b want 0", m_req); else n_pass++;
    i_req = 0; m_ready = 0; m_rdata = 32'hFFFF0000;
    tick();
    n_checks++; if (i_ack !== 1'b0) $display("FAIL fw_iack_c6: got %0b want 0", i_ack); else n_pass++;
    n_checks++; if (i_rdata !== 32'h12345678) $display("FAIL fw_rdata_hold: got %h want 12345678", i_rdata); else n_pass++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h300; m_ready = 1;
    tick();
    m_rdata = 32'hAAAA0001;
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h200 || m_wr !== 1'b0)
      $display("FAIL sim_dgrant: got m_req=%0b m_addr=%h m_wr=%0b want 1 00000200 0", m_req, m_addr, m_wr); else n_pass++;
    n_checks++; if (o_dbg_run_cnt !== 3'd1) $display("FAIL sim_runcnt_c1: got %0d want 1", o_dbg_run_cnt); else n_pass++;
    n_checks++; if (stall_if !== 1'b1) $display("FAIL sim_stallif: got %0b want 1", stall_if); else n_pass++;
    tick();
    n_checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hAAAA0001)
      $display("FAIL sim_dack: got d_ack=%0b d_rdata=%h want 1 aaaa0001", d_ack, d_rdata); else n_pass++;
    n_checks++; if (m_req !== 1'b0 || i_ack !== 1'b0)
      $display("FAIL sim_c2: got m_req=%0b i_ack=%0b want 0 0", m_req, i_ack); else n_pass++;
    d_req = 0;
    tick();
    m_rdata = 32'hBBBB0002;
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h300)
      $display("FAIL sim_igrant: got m_req=%0b m_addr=%h want 1 00000300", m_req, m_addr); else n_pass++;
    n_checks++; if (o_dbg_run_cnt !== 3'd0) $display("FAIL sim_runcnt_c3: got %0d want 0", o_dbg_run_cnt); else n_pass++;
    tick();
    n_checks++; if (i_ack !== 1'b1 || i_rdata !== 32'hBBBB0002)
      $display("FAIL sim_iack: got i_ack=%0b i_rdata=%h want 1 bbbb0002", i_ack, i_rdata); else n_pass++;
    i_req = 0;
    tick();
  endtask

  task automatic test_starvation;
    logic [9:0] got_seq;
    logic [9:0] exp_seq;
    logic       prev_mreq;
    int         n_g;
    int         max_cnt;
    got_seq = '0;
    exp_seq = 10'b10_0001_0000;
    prev_mreq = 0;
    n_g = 0;
    max_cnt = 0;
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 32'h500; i_addr = 32'h600; m_ready = 1;
    for (int cyc = 0; cyc < 200 && n_g < 10; cyc++) begin
      // fetch steps aside only in data-ack cycles, so every other IDLE cycle is a real tie
      i_req = ~d_ack;
      if (m_req && !prev_mreq) begin
        got_seq[n_g] = (m_addr == 32'h600);
        n_g++;
      end
      prev_mreq = m_req;
      if (int'(o_dbg_run_cnt) > max_cnt) max_cnt = int'(o_dbg_run_cnt);
      tick();
    end
    n_checks++; if (n_g != 10) $display("FAIL starve_grants: got %0d want 10 grants", n_g); else n_pass++;
    n_checks++; if (got_seq !== exp_seq) $display("FAIL starve_seq: got %b want %b (bit i = grant i, 1=fetch)", got_seq, exp_seq); else n_pass++;
    n_checks++; if (max_cnt != 4) $display("FAIL starve_maxcnt: got %0d want 4", max_cnt); else n_pass++;
    d_req = 0;
    tick();
    i_req = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    d_req = 1; d_wr = 1; d_addr = 32'h700; d_wdata = 32'h1234; m_ready = 0;
    tick();
    n_checks++; if (m_req !== 1'b1) $display("FAIL rm_busy: got %0b want 1", m_req); else n_pass++;
    tick();
    rst = 1;
    #1;
    n_checks++; if (m_req !== 1'b0 || m_wr !== 1'b0)
      $display("FAIL rm_mreq: got m_req=%0b m_wr=%0b want 0 0", m_req, m_wr); else n_pass++;
    n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL rm_state: got %0d want 0", o_dbg_state); else n_pass++;
    m_ready = 1;
    tick();
    n_checks++; if (d_ack !== 1'b0) $display("FAIL rm_no_dack: got %0b want 0", d_ack); else n_pass++;
    rst = 0;
    d_addr = 32'h704;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h704 || d_ack !== 1'b0)
      $display("FAIL rm_regrant: got m_req=%0b m_addr=%h d_ack=%0b want 1 00000704 0", m_req, m_addr, d_ack); else n_pass++;
    tick();
    n_checks++; if (d_ack !== 1'b1) $display("FAIL rm_dack: got %0b want 1", d_ack); else n_pass++;
    d_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fetch_wait();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
